// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// The key map is indexed [row][col], and its layout matches the physical keypad.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // When several rows are low at once, the lowest row index wins.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      lowest_low = 2'd0;
    else if (!r[1]) lowest_low = 2'd1;
    else if (!r[2]) lowest_low = 2'd2;
    else            lowest_low = 2'd3;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// The reset value can be set, so idle-high lines come out of reset as inactive.
module sync_2ff #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column rotation, press/release debounce,
// hex decode, and a two-digit history for the dual seven-segment display.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 48000,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output state_t     fsm_state
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rows_s;
  state_t        state, state_n;
  logic [SW-1:0] scan_cnt, scan_n;
  logic [DW-1:0] deb_cnt, deb_n;
  logic [1:0]    col_idx, col_n;
  logic [1:0]    row_idx, row_n;
  logic          accept;

  sync_2ff #(.WIDTH(4), .RESET_VALUE(4'b1111)) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SCAN;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      col_idx  <= '0;
      row_idx  <= '0;
    end else begin
      state    <= state_n;
      scan_cnt <= scan_n;
      deb_cnt  <= deb_n;
      col_idx  <= col_n;
      row_idx  <= row_n;
    end
  end

  always_comb begin
    state_n = state;
    scan_n  = scan_cnt;
    deb_n   = deb_cnt;
    col_n   = col_idx;
    row_n   = row_idx;
    accept  = 1'b0;
    case (state)
      SCAN: begin
        // Rows are sampled only in the last cycle of the slot. By then the column has settled and the synchronizer has caught up.
        if (scan_cnt == SCAN_LAST) begin
          scan_n = '0;
          if (rows_s != 4'b1111) begin
            row_n   = lowest_low(rows_s);
            deb_n   = '0;
            state_n = PRESS_DB;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          scan_n = scan_cnt + 1'b1;
        end
      end
      PRESS_DB: begin
        if (rows_s[row_idx]) begin
          scan_n  = '0;
          state_n = SCAN;
        end else if (deb_cnt == DEB_LAST) begin
          accept  = 1'b1;
          state_n = HELD;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (rows_s == 4'b1111) begin
          deb_n   = '0;
          state_n = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (rows_s != 4'b1111) begin
          deb_n = '0;
        end else if (deb_cnt == DEB_LAST) begin
          scan_n  = '0;
          state_n = SCAN;
        end else begin
          deb_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // The pulse is registered, so key_valid rises in the same cycle as the new key_code and digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      digit_new <= '0;
      digit_old <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code  <= KEYMAP[row_idx][col_idx];
        digit_new <= KEYMAP[row_idx][col_idx];
        digit_old <= digit_new;
      end
    end
  end

  assign cols      = ~(4'b0001 << col_idx);
  assign fsm_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized keypad bench: a matrix model drives the rows from the scanned column,
// and a scoreboard matches every key_valid pulse against the expected key history.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int LAT_BOUND = 2 + 4 * SD + DB + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code, digit_new, digit_old;
  state_t     fsm_state;

  logic [15:0] pressed = '0;
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic [11:0] exp_q[$];
  int dl_q[$];
  logic [3:0] model_new = '0, model_old = '0;
  logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                          4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // A pressed key pulls its row low only while the DUT drives that key's column low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_values();
    check("rst_cols", 16'(cols), 16'h000E);
    check("rst_valid", 16'(key_valid), 16'h0000);
    check("rst_code", 16'(key_code), 16'h0000);
    check("rst_new", 16'(digit_new), 16'h0000);
    check("rst_old", 16'(digit_old), 16'h0000);
    check("rst_state", 16'(fsm_state), 16'(SCAN));
  endtask

  // Call right after reset is released at a negedge. The columns walk one slot every SD cycles.
  task automatic check_scan(input int n);
    logic [3:0] e;
    for (int k = 0; k < n; k++) begin
      e = ~(4'b0001 << ((k / SD) % 4));
      check("scan_cols", 16'(cols), 16'(e));
      @(negedge clk);
    end
  endtask

  task automatic expect_key(input int r, input int c);
    logic [3:0] code;
    code = km[r*4+c];
    exp_q.push_back({code, code, model_new});
    dl_q.push_back(cycle + LAT_BOUND);
    model_old = model_new;
    model_new = code;
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    expect_key(r, c);
    pressed[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
  endtask

  // Every low run is at most 3 cycles, which is well short of the debounce window.
  task automatic bounce(input int r, input int c, input int total);
    int t, k;
    t = 0;
    while (t < total) begin
      pressed[r*4+c] = 1'b1;
      k = $urandom_range(1, 3);
      repeat (k) @(negedge clk);
      t += k;
      pressed[r*4+c] = 1'b0;
      k = $urandom_range(1, 3);
      repeat (k) @(negedge clk);
      t += k;
    end
    pressed = '0;
    repeat (20) @(negedge clk);
    check("bounce_state", 16'(fsm_state), 16'(SCAN));
  endtask

  task automatic reset_in(input state_t target, input int r, input int c);
    bit found;
    if (target == HELD) expect_key(r, c);
    pressed[r*4+c] = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (fsm_state == target) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_state actual=timeout required=%0d", target);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_values();
    pressed = '0;
    model_new = '0;
    model_old = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_scan(2 * 4 * SD);
  endtask

  // Scoreboard monitor
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
    end else begin
      if (key_valid && prev_valid) begin
        errors++;
        $display("FAIL valid_back_to_back actual=1 required=0");
      end
      if (key_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse actual=code %h required=no pulse", key_code);
        end else begin
          logic [11:0] e;
          int dl;
          e = exp_q.pop_front();
          dl = dl_q.pop_front();
          if ({key_code, digit_new, digit_old} !== e) begin
            errors++;
            $display("FAIL key_event actual=%h required=%h", {key_code, digit_new, digit_old}, e);
          end
          checks++;
          if (cycle > dl) begin
            errors++;
            $display("FAIL latency actual=%0d required<=%0d", cycle, dl);
          end
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    #1;
    check_reset_values();
    // Idle scanning: no keys are pressed, so the columns rotate and no pulse is expected.
    @(negedge clk);
    reset = 1'b0;
    check_scan(40);
    // A single steady key
    press_key(1, 1, 60);
    // Two keys in a row build up the history
    press_key(0, 0, 50);
    press_key(3, 1, 50);
    // Contact bounce
    bounce(2, 2, 30);
    // A second key pressed while the first is held is ignored
    expect_key(2, 3);
    pressed[2*4+3] = 1'b1;
    repeat (60) @(negedge clk);
    pressed[0*4+3] = 1'b1;
    repeat (140) @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
    // Randomized presses mixed with bounces
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0)
        bounce($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(10, 30));
      else
        press_key($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(40, 90));
    end
    // Reset during press debounce and during hold
    reset_in(PRESS_DB, 0, 2);
    reset_in(HELD, 3, 3);
    press_key(2, 0, 50);
    repeat (30) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
